// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter
//   Shares the single external data-memory port between the CPU M-stage data
//   port (M0) and an auxiliary DMA/debug master (M1). One transaction is in
//   flight at a time. A granted transaction is forwarded to the slave and
//   held until s_ack or a timeout abort. Each completion returns read data
//   and a one-cycle done pulse to the owning master.
//
// Ports
//   clk, reset                  clock, synchronous active-low reset
//   m0_req/addr/wdata/byteen    CPU request (byteen 4'b0000 = read)
//   m0_rdata, m0_done           CPU read data and completion pulse
//   m0_stall                    CPU must hold its M stage
//   m1_req/addr/wdata/byteen    auxiliary master request
//   m1_rdata, m1_done           auxiliary master read data and completion pulse
//   s_req/addr/wdata/byteen     forwarded transaction to the slave
//   s_ack, s_rdata              slave completion and read data
//   bus_err, bus_err_master     timeout abort pulse and owner of the aborted transaction
module dm_bus_arbiter #(
    parameter int MAX_CONSEC = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_byteen,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_stall,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_byteen,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        s_req,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_byteen,
    input  logic        s_ack,
    input  logic [31:0] s_rdata,
    output logic        bus_err,
    output logic        bus_err_master
);

    localparam logic [3:0] CONSEC_MAX = 4'(MAX_CONSEC);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  consec_q, consec_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        s_req_q, s_req_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [31:0] s_wdata_q, s_wdata_d;
    logic [3:0]  s_byteen_q, s_byteen_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        m0_done_q, m0_done_d;
    logic        m1_done_q, m1_done_d;
    logic        bus_err_q, bus_err_d;
    logic        bus_err_master_q, bus_err_master_d;

    logic busy;
    logic grant0;
    logic grant1;
    logic abort;

    // M0 wins ties unless it has already taken MAX_CONSEC grants in a row
    // while M1 was waiting.
    assign busy   = (state_q != IDLE);
    assign grant0 = !busy && m0_req && (!m1_req || (consec_q != CONSEC_MAX));
    assign grant1 = !busy && m1_req && !grant0;
    // An ack in the final timeout cycle takes priority over the abort.
    assign abort  = busy && !s_ack && (to_cnt_q == TO_LAST);

    // State register and all output/counter flops
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= IDLE;
            consec_q         <= '0;
            to_cnt_q         <= '0;
            last_grant_q     <= 1'b0;
            s_req_q          <= 1'b0;
            s_addr_q         <= '0;
            s_wdata_q        <= '0;
            s_byteen_q       <= '0;
            m0_rdata_q       <= '0;
            m1_rdata_q       <= '0;
            m0_done_q        <= 1'b0;
            m1_done_q        <= 1'b0;
            bus_err_q        <= 1'b0;
            bus_err_master_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            consec_q         <= consec_d;
            to_cnt_q         <= to_cnt_d;
            last_grant_q     <= last_grant_d;
            s_req_q          <= s_req_d;
            s_addr_q         <= s_addr_d;
            s_wdata_q        <= s_wdata_d;
            s_byteen_q       <= s_byteen_d;
            m0_rdata_q       <= m0_rdata_d;
            m1_rdata_q       <= m1_rdata_d;
            m0_done_q        <= m0_done_d;
            m1_done_q        <= m1_done_d;
            bus_err_q        <= bus_err_d;
            bus_err_master_q <= bus_err_master_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant0) begin
                    state_d = BUSY0;
                end else if (grant1) begin
                    state_d = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                if (s_ack || abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and counter logic; last_grant_q names the bus owner while busy.
    always_comb begin
        consec_d         = consec_q;
        to_cnt_d         = to_cnt_q;
        last_grant_d     = last_grant_q;
        s_req_d          = s_req_q;
        s_addr_d         = s_addr_q;
        s_wdata_d        = s_wdata_q;
        s_byteen_d       = s_byteen_q;
        m0_rdata_d       = m0_rdata_q;
        m1_rdata_d       = m1_rdata_q;
        m0_done_d        = 1'b0;
        m1_done_d        = 1'b0;
        bus_err_d        = 1'b0;
        bus_err_master_d = bus_err_master_q;

        if (grant0) begin
            s_req_d      = 1'b1;
            s_addr_d     = m0_addr;
            s_wdata_d    = m0_wdata;
            s_byteen_d   = m0_byteen;
            last_grant_d = 1'b0;
            to_cnt_d     = '0;
            consec_d     = m1_req ? consec_q + 4'd1 : 4'd0;
        end else if (grant1) begin
            s_req_d      = 1'b1;
            s_addr_d     = m1_addr;
            s_wdata_d    = m1_wdata;
            s_byteen_d   = m1_byteen;
            last_grant_d = 1'b1;
            to_cnt_d     = '0;
            consec_d     = 4'd0;
        end

        if (busy) begin
            if (s_ack || abort) begin
                s_req_d = 1'b0;
                // Writes load rdata too; an aborted transaction returns zero.
                if (last_grant_q) begin
                    m1_rdata_d = s_ack ? s_rdata : 32'h0000_0000;
                    m1_done_d  = 1'b1;
                end else begin
                    m0_rdata_d = s_ack ? s_rdata : 32'h0000_0000;
                    m0_done_d  = 1'b1;
                end
                if (abort) begin
                    bus_err_d        = 1'b1;
                    bus_err_master_d = last_grant_q;
                end
            end else begin
                to_cnt_d = to_cnt_q + 8'd1;
            end
        end
    end

    assign s_req          = s_req_q;
    assign s_addr         = s_addr_q;
    assign s_wdata        = s_wdata_q;
    assign s_byteen       = s_byteen_q;
    assign m0_rdata       = m0_rdata_q;
    assign m1_rdata       = m1_rdata_q;
    assign m0_done        = m0_done_q;
    assign m1_done        = m1_done_q;
    assign bus_err        = bus_err_q;
    assign bus_err_master = bus_err_master_q;
    assign m0_stall       = m0_req & ~m0_done_q;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb_dm_bus_arbiter
//   Directed-vector bench for dm_bus_arbiter (MAX_CONSEC=4, TIMEOUT=16).
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_dm_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_byteen;
    logic [31:0] m0_rdata;
    logic        m0_done;
    logic        m0_stall;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_byteen;
    logic [31:0] m1_rdata;
    logic        m1_done;
    logic        s_req;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_byteen;
    logic        s_ack;
    logic [31:0] s_rdata;
    logic        bus_err;
    logic        bus_err_master;

    int n_checks;
    int n_pass;

    dm_bus_arbiter #(
        .MAX_CONSEC(4),
        .TIMEOUT   (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m0_req        (m0_req),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_byteen     (m0_byteen),
        .m0_rdata      (m0_rdata),
        .m0_done       (m0_done),
        .m0_stall      (m0_stall),
        .m1_req        (m1_req),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_byteen     (m1_byteen),
        .m1_rdata      (m1_rdata),
        .m1_done       (m1_done),
        .s_req         (s_req),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_byteen      (s_byteen),
        .s_ack         (s_ack),
        .s_rdata       (s_rdata),
        .bus_err       (bus_err),
        .bus_err_master(bus_err_master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_m1 [10];
        int busy_cycles;
        bit ended;

        exp_m1 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        m0_req    = 1'b0;
        m0_addr   = '0;
        m0_wdata  = '0;
        m0_byteen = '0;
        m1_req    = 1'b0;
        m1_addr   = '0;
        m1_wdata  = '0;
        m1_byteen = '0;
        s_ack     = 1'b0;
        s_rdata   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_req", {31'd0, s_req}, 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_m0_done", {31'd0, m0_done}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        reset = 1'b1;

        // M0 read alone, immediate ack
        @(negedge clk);
        m0_req  = 1'b1;
        m0_addr = 32'h0000_0010;
        @(negedge clk);
        chk("t1_s_req", {31'd0, s_req}, 32'd1);
        chk("t1_s_addr", s_addr, 32'h0000_0010);
        chk("t1_stall_busy", {31'd0, m0_stall}, 32'd1);
        s_ack   = 1'b1;
        s_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("t1_s_req_drop", {31'd0, s_req}, 32'd0);
        chk("t1_m0_done", {31'd0, m0_done}, 32'd1);
        chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("t1_stall_done", {31'd0, m0_stall}, 32'd0);
        s_ack  = 1'b0;
        m0_req = 1'b0;
        @(negedge clk);
        chk("t1_done_pulse", {31'd0, m0_done}, 32'd0);
        chk("t1_s_req_idle", {31'd0, s_req}, 32'd0);

        // M1 write, ack in the third BUSY cycle
        m1_req    = 1'b1;
        m1_addr   = 32'h0000_7f04;
        m1_wdata  = 32'hDEAD_BEEF;
        m1_byteen = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_s_req", {31'd0, s_req}, 32'd1);
            chk("t2_s_addr", s_addr, 32'h0000_7f04);
            chk("t2_s_wdata", s_wdata, 32'hDEAD_BEEF);
            chk("t2_s_byteen", {28'd0, s_byteen}, 32'hF);
            chk("t2_m1_done_early", {31'd0, m1_done}, 32'd0);
            if (i == 2) begin
                s_ack   = 1'b1;
                s_rdata = 32'hAAAA_5555;
            end
        end
        @(negedge clk);
        chk("t2_m1_done", {31'd0, m1_done}, 32'd1);
        chk("t2_m0_done", {31'd0, m0_done}, 32'd0);
        chk("t2_m1_rdata", m1_rdata, 32'hAAAA_5555);
        s_ack  = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        chk("t2_done_pulse", {31'd0, m1_done}, 32'd0);

        // Both masters request continuously, slave acks at once
        m0_req  = 1'b1;
        m0_addr = 32'h0000_00A0;
        m1_req  = 1'b1;
        m1_addr = 32'h0000_00B0;
        m1_byteen = 4'b0000;
        s_ack   = 1'b1;
        s_rdata = 32'hCAFE_0001;
        for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            chk($sformatf("t3_grant%0d_addr", g), s_addr,
                (exp_m1[g] == 1) ? 32'h0000_00B0 : 32'h0000_00A0);
            @(negedge clk);
            chk($sformatf("t3_bubble%0d", g), {31'd0, s_req}, 32'd0);
            chk($sformatf("t3_done%0d", g), {30'd0, m1_done, m0_done},
                (exp_m1[g] == 1) ? 32'd2 : 32'd1);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        s_ack  = 1'b0;
        @(negedge clk);

        // M0 timeout, then a normal M1 transaction
        m0_req  = 1'b1;
        m0_addr = 32'h0000_0020;
        busy_cycles = 0;
        ended = 1'b0;
        for (int i = 0; i < 40 && !ended; i++) begin
            @(negedge clk);
            if (s_req) begin
                busy_cycles++;
                if (bus_err) chk("t4_err_early", {31'd0, bus_err}, 32'd0);
            end else begin
                ended = 1'b1;
            end
        end
        chk("t4_busy_cycles", busy_cycles, 32'd16);
        chk("t4_bus_err", {31'd0, bus_err}, 32'd1);
        chk("t4_err_master", {31'd0, bus_err_master}, 32'd0);
        chk("t4_m0_done", {31'd0, m0_done}, 32'd1);
        chk("t4_m0_rdata", m0_rdata, 32'd0);
        m0_req  = 1'b0;
        m1_req  = 1'b1;
        m1_addr = 32'h0000_0030;
        @(negedge clk);
        chk("t4_err_pulse", {31'd0, bus_err}, 32'd0);
        chk("t4_m1_grant", s_addr, 32'h0000_0030);
        s_ack   = 1'b1;
        s_rdata = 32'h0000_0055;
        @(negedge clk);
        chk("t4_m1_done", {31'd0, m1_done}, 32'd1);
        chk("t4_m1_rdata", m1_rdata, 32'h0000_0055);
        m1_req = 1'b0;
        s_ack  = 1'b0;
        @(negedge clk);

        // Reset in the second BUSY cycle of an M1 read
        m1_req  = 1'b1;
        m1_addr = 32'h0000_0040;
        @(negedge clk);
        chk("t5_busy1", {31'd0, s_req}, 32'd1);
        @(negedge clk);
        reset  = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        chk("t5_s_req", {31'd0, s_req}, 32'd0);
        chk("t5_m1_done", {31'd0, m1_done}, 32'd0);
        chk("t5_m1_rdata", m1_rdata, 32'd0);
        chk("t5_s_addr", s_addr, 32'd0);
        reset   = 1'b1;
        m0_req  = 1'b1;
        m0_addr = 32'h0000_0050;
        @(negedge clk);
        chk("t5_m0_grant", s_addr, 32'h0000_0050);
        s_ack   = 1'b1;
        s_rdata = 32'h0000_0077;
        @(negedge clk);
        chk("t5_m0_done", {31'd0, m0_done}, 32'd1);
        chk("t5_m0_rdata", m0_rdata, 32'h0000_0077);
        m0_req = 1'b0;
        s_ack  = 1'b0;
        @(negedge clk);

        // Ack in the same cycle the timeout would fire
        m0_req  = 1'b1;
        m0_addr = 32'h0000_0060;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 16) begin
                chk("t6_still_busy", {31'd0, s_req}, 32'd1);
                s_ack   = 1'b1;
                s_rdata = 32'h0000_9ABC;
            end
        end
        @(negedge clk);
        chk("t6_m0_done", {31'd0, m0_done}, 32'd1);
        chk("t6_bus_err", {31'd0, bus_err}, 32'd0);
        chk("t6_m0_rdata", m0_rdata, 32'h0000_9ABC);
        m0_req = 1'b0;
        s_ack  = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dm_bus_arbiter.md
Name: dm_bus_arbiter

Overview:
- Shares the single external data-memory port between two masters: the CPU M-stage data port (M0) and an auxiliary DMA/debug master (M1).
- Sits between the CPU's m_data_* interface and the DM/bridge slave.
- Each master issues one transaction at a time. The arbiter grants, forwards the transaction to the slave, waits for the slave's acknowledge, and returns the read data and a done pulse.
- Also provides a stall to the CPU pipeline and a bus-timeout error.

Parameters:
- MAX_CONSEC, 4: maximum consecutive M0 grants while M1 is waiting; the next grant is then forced to M1. Range 1..15.
- TIMEOUT, 16: cycles a slave transaction may stay unacknowledged before it is aborted. Range 2..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- m0_req  in  1  CPU requests a transaction; held high until m0_done.
- m0_addr  in  32  CPU byte address.
- m0_wdata  in  32  CPU write data, already lane-shifted.
- m0_byteen  in  4  write byte enables; 4'b0000 = read.
- m0_rdata  out  32  read data returned to the CPU.
- m0_done  out  1  one-cycle completion pulse to the CPU.
- m0_stall  out  1  CPU must hold its M stage.
- m1_req, m1_addr, m1_wdata, m1_byteen  in  1/32/32/4  same meaning for M1.
- m1_rdata  out  32  read data returned to M1.
- m1_done  out  1  one-cycle completion pulse to M1.
- s_req  out  1  slave transaction active.
- s_addr  out  32  forwarded address.
- s_wdata  out  32  forwarded write data.
- s_byteen  out  4  forwarded byte enables.
- s_ack  in  1  slave completes the current transaction this cycle.
- s_rdata  in  32  slave read data, valid when s_ack=1.
- bus_err  out  1  one-cycle pulse on a timeout abort.
- bus_err_master  out  1  master that owned the aborted transaction (0 = M0, 1 = M1); held until the next error.

Behaviour:
- States: IDLE, BUSY0, BUSY1.
- Reset (reset=0 at an edge):
  - State goes to IDLE.
  - All outputs go to 0: s_req, s_addr, s_wdata, s_byteen, m0_done, m1_done, m0_rdata, m1_rdata, bus_err, bus_err_master.
  - Consecutive counter, timeout counter and last-grant all go to 0.
  - Reset mid-transaction drops the transaction silently. s_req is low from the next cycle and no done pulse is issued.
- Arbitration (IDLE only):
  - Exactly one requester: grant it.
  - Both requesting: grant M0, unless consec_cnt == MAX_CONSEC, in which case grant M1.
  - consec_cnt increments on each M0 grant made while m1_req=1.
  - consec_cnt clears on any M1 grant, and on any M0 grant made while m1_req=0.
- Grant:
  - At the IDLE edge where a grant is made, latch the master's addr, wdata and byteen into s_addr, s_wdata and s_byteen, set s_req=1, and go to BUSYx.
  - The slave sees the request the cycle after the master's request is sampled.
  - s_* outputs are stable for the whole BUSY period.
- Completion:
  - In BUSYx with s_ack=1: at the edge, register s_rdata into mx_rdata (writes also load it), pulse mx_done for exactly one cycle, drop s_req, and return to IDLE.
  - mx_rdata holds its value until the next completion for that master.
  - Minimum latency, req to done: request sampled at edge t, s_req high in cycle t+1, s_ack in t+1, done high in t+2.
  - One IDLE bubble always follows a completion. A master that holds req after done is treated as a new transaction.
- Timeout:
  - The timeout counter clears on entering BUSY and increments each BUSY cycle with s_ack=0.
  - When it reaches TIMEOUT-1 with s_ack=0: abort at that edge, go to IDLE, drop s_req, pulse bus_err, set bus_err_master, and pulse mx_done with mx_rdata = 32'h0000_0000.
  - If s_ack and the timeout coincide, the ack wins: normal completion, no error.
- m0_stall = m0_req & ~m0_done (combinational).
- s_ack received while IDLE is ignored.
- A master deasserting req while it owns the bus has no effect; the transaction still completes.

Test Plan:
- M0 read alone at addr 0x0000_0010, slave acks in the first BUSY cycle with rdata 0x1234_5678 -> s_req high exactly one cycle, m0_done one cycle later, m0_rdata = 0x1234_5678, m0_stall low in the done cycle.
- M1 write addr 0x7f04, byteen 4'b1111, data 0xDEAD_BEEF, slave acks after 3 cycles -> s_addr/s_wdata/s_byteen stable for all 3 BUSY cycles, m1_done single pulse, m0_done stays 0.
- Both masters request continuously, slave acks immediately, MAX_CONSEC=4 -> grant sequence M0,M0,M0,M0,M1,M0,M0,M0,M0,M1, one IDLE bubble between grants.
- M0 transaction with s_ack never asserted, TIMEOUT=16 -> abort after 16 BUSY cycles, bus_err one pulse, bus_err_master=0, m0_done pulse with m0_rdata=0, next M1 request granted normally.
- reset driven low in the 2nd BUSY cycle of an M1 read -> next cycle s_req=0 and state IDLE, no m1_done, all outputs 0, next M0 request serviced with normal latency.
- s_ack arrives in the same cycle the timeout count reaches TIMEOUT-1 -> normal completion, bus_err stays 0, rdata = slave data.
